// File: rtl/image_pkg.sv
// image_pkg: shared size defaults, FSM encoding and power-up pixel pattern for image_memory.
package image_pkg;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_COLS  = 4;
    localparam int DEF_WIDTH = 32;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    // -1 on the border, +1 inside, returned sign-extended and masked to width bits
    function automatic logic [63:0] default_pixel(input int r, input int c, input int rows,
                                                  input int cols, input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ((r == 0 || r == rows - 1 || c == 0 || c == cols - 1) ? '1 : 64'd1) & mask;
    endfunction
endpackage

// File: rtl/image_bank.sv
// image_bank: ROWS x COLS pixel register file with one write port and full parallel read.
module image_bank
    import image_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int WIDTH = DEF_WIDTH,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  we,
    input  logic [RW-1:0]                         row,
    input  logic [CW-1:0]                         col,
    input  logic [WIDTH-1:0]                      wdata,
    output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  data
);
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] mem_q, mem_d, dflt;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam logic [63:0] D = default_pixel(r, c, ROWS, COLS, WIDTH);
            assign dflt[r][c] = D[WIDTH-1:0];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[row][col] = wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mem_q <= dflt;
        else       mem_q <= mem_d;
    end

    assign data = mem_q;
endmodule

// File: rtl/image_memory.sv
// image_memory: double-buffered frame store; raster pixels fill the shadow bank, which is
// swapped in as the active bank once full and the consumer has released the current frame.
module image_memory
    import image_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [WIDTH-1:0]                      in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  abort,
    input  logic                                  frame_done,
    output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  memory_output,
    output logic                                  frame_valid
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t                               state_q, state_d;
    logic [RW-1:0]                        row_q, row_d;
    logic [CW-1:0]                        col_q, col_d;
    logic                                 bank_q, bank_d;
    logic                                 frame_valid_q, frame_valid_d;
    logic                                 accept, last, swap;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] data0, data1;

    assign in_ready = (state_q == FILL);
    assign accept   = in_valid && in_ready && !abort;
    assign last     = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign swap     = (state_q == FULL) && !abort && (!frame_valid_q || frame_done);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        bank_d        = bank_q;
        frame_valid_d = swap ? 1'b1 : (frame_valid_q && !frame_done);
        if (abort) begin
            state_d = FILL;
            row_d   = '0;
            col_d   = '0;
        end else if (swap) begin
            state_d = FILL;
            bank_d  = !bank_q;
        end else if (accept) begin
            col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            row_d   = (col_q != COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            state_d = last ? FULL : FILL;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            row_q         <= '0;
            col_q         <= '0;
            bank_q        <= 1'b0;
            frame_valid_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bank_q        <= bank_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // bank_q names the active bank; writes only ever go to the other one
    image_bank #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_bank0 (
        .clock (clock),
        .reset (reset),
        .we    (accept && bank_q),
        .row   (row_q),
        .col   (col_q),
        .wdata (in_data),
        .data  (data0)
    );

    image_bank #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_bank1 (
        .clock (clock),
        .reset (reset),
        .we    (accept && !bank_q),
        .row   (row_q),
        .col   (col_q),
        .wdata (in_data),
        .data  (data1)
    );

    assign memory_output = bank_q ? data1 : data0;
    assign frame_valid   = frame_valid_q;
endmodule
